regfile_mp: RTL and testbench

Parametrised multi-port integer register file for the Lexington core, replacing the fixed 2R1W file. It adds configurable read and write port counts, optional write-to-read bypass and asynchronous clear of all registers. It also integrates a per-register pending-write scoreboard that decode uses to detect RAW hazards for multi-issue and long-latency units. It sits between decode/issue (reads, reservations) and writeback (writes, releases).

---
 rtl/regfile_mp_pkg.sv | 17 +
 rtl/regfile_mp_scoreboard.sv | 55 +++++
 rtl/regfile_mp.sv | 66 ++++++
 tb/tb_regfile_mp.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: rv32 register types and lexington register-file defaults
package rv32;
  localparam int REG_COUNT = 32;
  typedef logic [4:0] gpr_addr_t;
  typedef logic [31:0] word;
endpackage

package lexington;
  localparam int NUM_RD_DEF = 2;
  localparam int NUM_WR_DEF = 1;
  localparam int PEND_W_DEF = 2;
  typedef logic [PEND_W_DEF-1:0] pend_cnt_t;
  typedef struct packed {
    logic            en;
    rv32::gpr_addr_t addr;
  } rf_rd_port_t;
endpackage

// File: rtl/regfile_mp_scoreboard.sv
// regfile_scoreboard: per-register outstanding-write counters, reservation accept and busy lookup
module regfile_scoreboard
  import rv32::*;
#(
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1,
  parameter int PEND_W = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic      [NUM_RD-1:0] rd_en,
  input  gpr_addr_t [NUM_RD-1:0] rd_addr,
  input  logic      [NUM_WR-1:0] wr_en,
  input  gpr_addr_t [NUM_WR-1:0] wr_addr,
  input  logic                   rsv_en,
  input  gpr_addr_t              rsv_addr,
  input  logic                   flush,
  output logic      [NUM_RD-1:0] rd_busy,
  output logic                   rsv_ready
);
  localparam logic [PEND_W-1:0] MAX = '1;
  logic [PEND_W-1:0] r_pend [1:REG_COUNT-1];
  logic [PEND_W-1:0] w_next [1:REG_COUNT-1];
  logic [PEND_W-1:0] w_pend [REG_COUNT];
  logic              w_rsv_acc;
  int                w_sum;
  for (genvar r = 0; r < REG_COUNT; r++) begin : g_dbg
    if (r == 0) begin : g_x0
      assign w_pend[r] = '0;
    end else begin : g_xn
      assign w_pend[r] = r_pend[r];
    end
  end
  assign rsv_ready = !(rsv_en && rsv_addr != '0 && w_pend[rsv_addr] == MAX);
  assign w_rsv_acc = rsv_en && rsv_addr != '0 && rsv_ready;
  // releases below zero saturate so untracked writes stay legal
  always_comb begin
    w_sum = 0;
    for (int r = 1; r < REG_COUNT; r++) begin
      w_sum = int'(r_pend[r]) + int'(w_rsv_acc && rsv_addr == gpr_addr_t'(r));
      for (int j = 0; j < NUM_WR; j++)
        w_sum = w_sum - int'(wr_en[j] && wr_addr[j] == gpr_addr_t'(r));
      w_next[r] = (flush || w_sum < 0) ? '0 : PEND_W'(w_sum);
    end
  end
  always_comb begin
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++)
      rd_busy[i] = rd_en[i] && rd_addr[i] != '0 && w_pend[rd_addr[i]] != '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pend <= '{default: '0};
    else r_pend <= w_next;
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with write bypass and pending-write scoreboard
module regfile_mp
  import rv32::*;
  import lexington::*;
#(
  parameter int NUM_RD = NUM_RD_DEF,
  parameter int NUM_WR = NUM_WR_DEF,
  parameter bit BYPASS = 1'b1,
  parameter int PEND_W = PEND_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic      [NUM_RD-1:0] rd_en,
  input  gpr_addr_t [NUM_RD-1:0] rd_addr,
  output word       [NUM_RD-1:0] rd_data,
  output logic      [NUM_RD-1:0] rd_busy,
  input  logic      [NUM_WR-1:0] wr_en,
  input  gpr_addr_t [NUM_WR-1:0] wr_addr,
  input  word       [NUM_WR-1:0] wr_data,
  input  logic                   rsv_en,
  input  gpr_addr_t              rsv_addr,
  output logic                   rsv_ready,
  input  logic                   flush
);
  word                       r_mem [1:REG_COUNT-1];
  word                       w_data [REG_COUNT];
  rf_rd_port_t [NUM_RD-1:0]  w_rd;
  for (genvar r = 0; r < REG_COUNT; r++) begin : g_dbg
    if (r == 0) begin : g_x0
      assign w_data[r] = '0;
    end else begin : g_xn
      assign w_data[r] = r_mem[r];
    end
  end
  // later write ports overwrite earlier ones on an address conflict
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_mem <= '{default: '0};
    else
      for (int j = 0; j < NUM_WR; j++)
        if (wr_en[j] && wr_addr[j] != '0) r_mem[wr_addr[j]] <= wr_data[j];
  end
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      w_rd[i] = '{en: rd_en[i], addr: rd_addr[i]};
      if (w_rd[i].en && w_rd[i].addr != '0 && !rst) begin
        rd_data[i] = w_data[w_rd[i].addr];
        for (int j = 0; j < NUM_WR; j++)
          if (BYPASS && wr_en[j] && wr_addr[j] == w_rd[i].addr) rd_data[i] = wr_data[j];
      end
    end
  end
  regfile_scoreboard #(.NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .PEND_W(PEND_W)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .flush     (flush),
    .rd_busy   (rd_busy),
    .rsv_ready (rsv_ready)
  );
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed and random checks of regfile_mp against an array-based reference model
module tb_regfile_mp;
  logic             clk = 0;
  logic             rst;
  logic [1:0]       rd_en;
  logic [1:0][4:0]  rd_addr;
  logic [1:0][31:0] rd_data, rd_data_nb;
  logic [1:0]       rd_busy, rd_busy_nb;
  logic [1:0]       wr_en;
  logic [1:0][4:0]  wr_addr;
  logic [1:0][31:0] wr_data;
  logic             rsv_en;
  logic [4:0]       rsv_addr;
  logic             rsv_ready, rsv_ready_nb;
  logic             flush;
  logic [31:0]      m_mem [32];
  int               m_pend [32];
  int               total = 0;
  int               bad = 0;
  int               cyc = 0;
  always #5 clk = ~clk;
  regfile_mp #(.NUM_RD(2), .NUM_WR(2), .BYPASS(1'b1), .PEND_W(2)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready), .flush(flush)
  );
  regfile_mp #(.NUM_RD(2), .NUM_WR(2), .BYPASS(1'b0), .PEND_W(2)) dut_nb (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_nb),
    .rd_busy(rd_busy_nb), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready_nb), .flush(flush)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask
  function automatic logic [31:0] exp_rd(int i, bit byp);
    logic [31:0] v;
    if (rst || !rd_en[i] || rd_addr[i] == 0) return 0;
    v = m_mem[rd_addr[i]];
    if (byp)
      for (int j = 0; j < 2; j++)
        if (wr_en[j] && wr_addr[j] == rd_addr[i]) v = wr_data[j];
    return v;
  endfunction
  function automatic logic exp_busy(int i);
    return !rst && rd_en[i] && rd_addr[i] != 0 && m_pend[rd_addr[i]] != 0;
  endfunction
  function automatic logic exp_ready();
    return rst || !(rsv_en && rsv_addr != 0 && m_pend[rsv_addr] == 3);
  endfunction
  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_mem[r] = 0;
      m_pend[r] = 0;
    end
  endtask
  task automatic model_edge();
    int n;
    if (rst) begin
      model_reset();
      return;
    end
    for (int r = 1; r < 32; r++) begin
      n = m_pend[r];
      if (rsv_en && rsv_addr == r && m_pend[r] < 3) n++;
      for (int j = 0; j < 2; j++) if (wr_en[j] && wr_addr[j] == r) n--;
      m_pend[r] = (flush || n < 0) ? 0 : n;
    end
    for (int j = 0; j < 2; j++) if (wr_en[j] && wr_addr[j] != 0) m_mem[wr_addr[j]] = wr_data[j];
  endtask
  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rd_data%0d", i), rd_data[i], exp_rd(i, 1));
      chk($sformatf("rd_data_nobyp%0d", i), rd_data_nb[i], exp_rd(i, 0));
      chk($sformatf("rd_busy%0d", i), 32'(rd_busy[i]), 32'(exp_busy(i)));
      chk($sformatf("rd_busy_nobyp%0d", i), 32'(rd_busy_nb[i]), 32'(exp_busy(i)));
    end
    chk("rsv_ready", 32'(rsv_ready), 32'(exp_ready()));
    chk("rsv_ready_nobyp", 32'(rsv_ready_nb), 32'(exp_ready()));
  endtask
  task automatic cycle();
    #1 check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
  endtask
  task automatic idle();
    rd_en = 0; rd_addr = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
    rsv_en = 0; rsv_addr = 0; flush = 0;
  endtask
  task automatic rd(input logic [4:0] a);
    rd_en = 2'b11; rd_addr[0] = a; rd_addr[1] = a;
  endtask
  task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
    wr_en[p] = 1; wr_addr[p] = a; wr_data[p] = d;
  endtask
  task automatic rsv(input logic [4:0] a);
    rsv_en = 1; rsv_addr = a;
  endtask
  initial begin
    model_reset();
    idle();
    rst = 1;
    rd(5); wr(0, 5, 32'h1111_2222); rsv(5);
    cycle();
    rst = 0;
    idle(); rd(5); cycle();
    idle(); rd(5); wr(0, 5, 32'hDEAD_BEEF); cycle();
    idle(); rd(5); cycle();
    idle(); rd(0); wr(0, 0, 32'h1234); cycle();
    idle(); rd(0); cycle();
    idle(); rd(7); wr(0, 7, 32'hA5A5_A5A5); cycle();
    idle(); rsv(3); cycle();
    rsv(3); cycle();
    idle(); rd(3); wr(0, 3, 32'h11); wr(1, 3, 32'h22); cycle();
    idle(); rd(3); cycle();
    for (int k = 0; k < 4; k++) begin
      idle(); rd(9); rsv(9); cycle();
    end
    for (int k = 0; k < 3; k++) begin
      idle(); rd(9); wr(k % 2, 9, 32'h900 + k); cycle();
    end
    idle(); rd(9); rsv(9); cycle();
    rsv(9); wr(0, 9, 32'h999); cycle();
    idle(); rd(9); cycle();
    idle(); rd(9); wr(1, 9, 32'h99A); cycle();
    idle(); rd(9); cycle();
    idle(); rsv(4); cycle();
    idle(); rsv(6); cycle();
    idle(); rd(4); flush = 1; rsv(4); cycle();
    idle(); rd_en = 2'b11; rd_addr[0] = 4; rd_addr[1] = 6; cycle();
    idle(); rd(4); wr(0, 4, 32'hCAFE_F00D); cycle();
    idle(); rd(4); cycle();
    idle(); wr(0, 2, 32'h55); cycle();
    idle(); rsv(2); cycle();
    rsv(2); cycle();
    idle(); rd(2); cycle();
    #2;
    rst = 1;
    wr(0, 2, 32'h77);
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    rst = 0;
    idle(); rd(2); cycle();
    for (int k = 0; k < 400; k++) begin
      rd_en = 2'($urandom);
      rd_addr[0] = 5'($urandom_range(0, 7));
      rd_addr[1] = 5'($urandom_range(0, 7));
      wr_en = 2'($urandom);
      wr_addr[0] = 5'($urandom_range(0, 7));
      wr_addr[1] = 5'($urandom_range(0, 7));
      wr_data[0] = $urandom;
      wr_data[1] = $urandom;
      rsv_en = ($urandom_range(0, 3) != 0);
      rsv_addr = 5'($urandom_range(0, 7));
      flush = ($urandom_range(0, 19) == 0);
      cycle();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
